// File: rtl/dmem_pipe_if.sv
// Load/store request bus and response bus for dmem_pipe.
// The slave modport is the memory side, the master modport is the load/store unit.
interface dmem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              req;
    logic              ready;
    logic              write_en;
    logic              l_unsigned;
    logic [1:0]        n_bytes;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] store_data;
    logic              rsp_valid;
    logic [WORD_W-1:0] load_data;
    logic              addr_err;
    logic              align_err;

    modport master (
        output req, write_en, l_unsigned, n_bytes, addr, store_data,
        input  ready, rsp_valid, load_data, addr_err, align_err
    );

    modport slave (
        input  req, write_en, l_unsigned, n_bytes, addr, store_data,
        output ready, rsp_valid, load_data, addr_err, align_err
    );
endinterface

// File: rtl/dmem_pipe.sv
// Word-banked data memory with byte-lane stores, RD_LAT-deep response pipeline
// and an optional two-beat split for accesses that straddle a word boundary.
module dmem_pipe #(
    parameter int DMEM_SIZE   = 65536,
    parameter int START_ADDR  = 16384,
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int RD_LAT      = 1,
    parameter bit MISALIGN_EN = 1'b1
) (
    input logic        clk,
    input logic        rst,
    dmem_pipe_if.slave bus
);
    localparam int DEPTH = (DMEM_SIZE - START_ADDR) / 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              addr_err;
        logic              align_err;
    } rsp_t;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    rsp_t [RD_LAT-1:0] pipe_q, pipe_d;
    // Beat1 context, captured when a split access is accepted.
    logic [IDX_W-1:0]  spl_idx_q, spl_idx_d;
    logic [WORD_W-1:0] spl_wdata_q, spl_wdata_d;
    logic [3:0]        spl_mask_q, spl_mask_d;
    logic [WORD_W-1:0] spl_lo_q, spl_lo_d;
    logic              spl_we_q, spl_we_d;
    logic              spl_uns_q, spl_uns_d;
    logic [1:0]        spl_nb_q, spl_nb_d;
    logic [1:0]        spl_lane_q, spl_lane_d;

    logic                accept, size_rsv, in_range, misaligned, do_access, do_split;
    logic [2:0]          n_len;
    logic [ADDR_W:0]     last_addr;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          len_mask;
    logic [7:0]          lane_mask;
    logic [2*WORD_W-1:0] wdata_win;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [3:0]          wr_mask;
    logic [WORD_W-1:0]   wr_data;
    rsp_t                rsp_in;

    // win holds {high word, low word}; the access starts at byte `lane` of the low word.
    function automatic logic [WORD_W-1:0] extract(input logic [2*WORD_W-1:0] win,
                                                  input logic [1:0] lane,
                                                  input logic [1:0] nb,
                                                  input logic uns);
        logic [WORD_W-1:0] sh;
        sh = WORD_W'(win >> {lane, 3'b000});
        case (nb)
            2'b00:   extract = {{(WORD_W-8){~uns & sh[7]}}, sh[7:0]};
            2'b01:   extract = {{(WORD_W-16){~uns & sh[15]}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    assign bus.ready     = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = pipe_q[RD_LAT-1].valid;
    assign bus.load_data = pipe_q[RD_LAT-1].data;
    assign bus.addr_err  = pipe_q[RD_LAT-1].addr_err;
    assign bus.align_err = pipe_q[RD_LAT-1].align_err;

    always_comb begin
        accept   = bus.req && bus.ready;
        size_rsv = (bus.n_bytes == 2'b11);
        case (bus.n_bytes)
            2'b01:   n_len = 3'd2;
            2'b10:   n_len = 3'd4;
            default: n_len = 3'd1;
        endcase
        last_addr  = {1'b0, bus.addr} + (ADDR_W+1)'(n_len - 3'd1);
        in_range   = (bus.addr >= ADDR_W'(START_ADDR)) &&
                     (last_addr <= (ADDR_W+1)'(DMEM_SIZE - 1));
        misaligned = ({1'b0, bus.addr[1:0]} + n_len) > 3'd4;
        idx        = IDX_W'((bus.addr - ADDR_W'(START_ADDR)) >> 2);
        len_mask   = (bus.n_bytes == 2'b00) ? 4'b0001 :
                     (bus.n_bytes == 2'b01) ? 4'b0011 : 4'b1111;
        lane_mask  = {4'b0000, len_mask} << bus.addr[1:0];
        wdata_win  = {{WORD_W{1'b0}}, bus.store_data} << {bus.addr[1:0], 3'b000};
        do_access  = accept && in_range && !size_rsv && (!misaligned || MISALIGN_EN);
        do_split   = do_access && misaligned;
    end

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        spl_idx_d   = spl_idx_q;
        spl_wdata_d = spl_wdata_q;
        spl_mask_d  = spl_mask_q;
        spl_lo_d    = spl_lo_q;
        spl_we_d    = spl_we_q;
        spl_uns_d   = spl_uns_q;
        spl_nb_d    = spl_nb_q;
        spl_lane_d  = spl_lane_q;
        wr_en       = 1'b0;
        wr_idx      = idx;
        wr_mask     = lane_mask[3:0];
        wr_data     = wdata_win[WORD_W-1:0];
        rsp_in      = '0;

        if (state_q == ST_SPLIT) begin
            state_d      = ST_IDLE;
            wr_en        = spl_we_q;
            wr_idx       = spl_idx_q;
            wr_mask      = spl_mask_q;
            wr_data      = spl_wdata_q;
            rsp_in.valid = 1'b1;
            if (!spl_we_q)
                rsp_in.data = extract({mem[spl_idx_q], spl_lo_q}, spl_lane_q, spl_nb_q, spl_uns_q);
        end else if (accept) begin
            rsp_in.valid     = !do_split;
            rsp_in.addr_err  = !in_range;
            rsp_in.align_err = in_range && (size_rsv || (misaligned && !MISALIGN_EN));
            wr_en            = do_access && bus.write_en;
            if (do_access && !do_split && !bus.write_en)
                rsp_in.data = extract({{WORD_W{1'b0}}, mem[idx]}, bus.addr[1:0],
                                      bus.n_bytes, bus.l_unsigned);
            if (do_split) begin
                state_d     = ST_SPLIT;
                spl_idx_d   = idx + IDX_W'(1);
                spl_wdata_d = wdata_win[2*WORD_W-1:WORD_W];
                spl_mask_d  = lane_mask[7:4];
                spl_lo_d    = mem[idx];
                spl_we_d    = bus.write_en;
                spl_uns_d   = bus.l_unsigned;
                spl_nb_d    = bus.n_bytes;
                spl_lane_d  = bus.addr[1:0];
            end
        end
    end

    always_comb begin
        pipe_d[0] = rsp_in;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pipe_q      <= '0;
            spl_idx_q   <= '0;
            spl_wdata_q <= '0;
            spl_mask_q  <= '0;
            spl_lo_q    <= '0;
            spl_we_q    <= 1'b0;
            spl_uns_q   <= 1'b0;
            spl_nb_q    <= '0;
            spl_lane_q  <= '0;
        end else begin
            state_q     <= state_d;
            pipe_q      <= pipe_d;
            spl_idx_q   <= spl_idx_d;
            spl_wdata_q <= spl_wdata_d;
            spl_mask_q  <= spl_mask_d;
            spl_lo_q    <= spl_lo_d;
            spl_we_q    <= spl_we_d;
            spl_uns_q   <= spl_uns_d;
            spl_nb_q    <= spl_nb_d;
            spl_lane_q  <= spl_lane_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a reset mid-split keeps beat0 bytes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: dut_a (RD_LAT=2, split enabled) and dut_b (RD_LAT=1, split disabled).
module tb_dmem_pipe;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_pipe_if #(.ADDR_W(32), .WORD_W(32)) bus_a ();
    dmem_pipe_if #(.ADDR_W(32), .WORD_W(32)) bus_b ();

    dmem_pipe #(.RD_LAT(LAT_A), .MISALIGN_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_pipe #(.RD_LAT(LAT_B), .MISALIGN_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rq, input logic we, input logic uns,
                         input logic [1:0] nb, input logic [31:0] a, input logic [31:0] sd);
        if (sel) begin
            bus_b.req = rq; bus_b.write_en = we; bus_b.l_unsigned = uns;
            bus_b.n_bytes = nb; bus_b.addr = a; bus_b.store_data = sd;
        end else begin
            bus_a.req = rq; bus_a.write_en = we; bus_a.l_unsigned = uns;
            bus_a.n_bytes = nb; bus_a.addr = a; bus_a.store_data = sd;
        end
    endtask

    // One request; checks ready, ready one cycle later, response latency, data and error flags.
    task automatic do_req(input bit sel, input string tag, input logic we, input logic uns,
                          input logic [1:0] nb, input logic [31:0] a, input logic [31:0] sd,
                          input bit split, input logic [31:0] exp_data,
                          input logic [31:0] dmask, input logic exp_ae, input logic exp_le);
        int          lat;
        logic        rdy1;
        logic [31:0] d;
        logic        ae, le;
        lat = 0; rdy1 = 1'b0; d = '0; ae = 1'b0; le = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, we, uns, nb, a, sd);
        check({tag, " ready_in"}, 32'(sel ? bus_b.ready : bus_a.ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                drive(sel, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                rdy1 = sel ? bus_b.ready : bus_a.ready;
            end
            if (sel ? bus_b.rsp_valid : bus_a.rsp_valid) begin
                lat = k;
                d   = sel ? bus_b.load_data : bus_a.load_data;
                ae  = sel ? bus_b.addr_err  : bus_a.addr_err;
                le  = sel ? bus_b.align_err : bus_a.align_err;
                break;
            end
        end
        check({tag, " ready_next"}, 32'(rdy1), 32'(!split));
        check({tag, " latency"}, 32'(lat), 32'((sel ? LAT_B : LAT_A) + int'(split)));
        check({tag, " data"}, d & dmask, exp_data & dmask);
        check({tag, " addr_err"}, 32'(ae), 32'(exp_ae));
        check({tag, " align_err"}, 32'(le), 32'(exp_le));
    endtask

    function automatic logic [31:0] b2b_val(input int i);
        return 32'h01010101 * 32'(i + 1);
    endfunction

    initial begin
        int n_rsp, first_k, last_k;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ready", 32'(bus_a.ready), 32'd0);
        check("rst rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst load_data", bus_a.load_data, 32'h0);
        check("rst addr_err", 32'(bus_a.addr_err), 32'd0);
        check("rst align_err", 32'(bus_a.align_err), 32'd0);
        rst = 1'b0;
        #1 check("post-rst ready", 32'(bus_a.ready), 32'd1);

        // Aligned round trip and sub-word extension.
        do_req(0, "sw 4000", 1, 0, 2'b10, 32'h4000, 32'hDEADBEEF, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lw 4000", 0, 0, 2'b10, 32'h4000, 32'h0, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lb 4003", 0, 0, 2'b00, 32'h4003, 32'h0, 0, 32'hFFFFFFDE, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lbu 4003", 0, 1, 2'b00, 32'h4003, 32'h0, 0, 32'h000000DE, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lh 4002", 0, 0, 2'b01, 32'h4002, 32'h0, 0, 32'hFFFFDEAD, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lhu 4002", 0, 1, 2'b01, 32'h4002, 32'h0, 0, 32'h0000DEAD, 32'hFFFFFFFF, 0, 0);

        // Split store/load.
        do_req(0, "sw 4006 split", 1, 0, 2'b10, 32'h4006, 32'h11223344, 1, 32'h0, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lw 4006 split", 0, 0, 2'b10, 32'h4006, 32'h0, 1, 32'h11223344, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lw 4004 hi", 0, 0, 2'b10, 32'h4004, 32'h0, 0, 32'h33440000, 32'hFFFF0000, 0, 0);
        do_req(0, "lw 4008 lo", 0, 0, 2'b10, 32'h4008, 32'h0, 0, 32'h00001122, 32'h0000FFFF, 0, 0);

        // Range and size errors; top-of-region boundary.
        do_req(0, "lw 3ffc", 0, 0, 2'b10, 32'h3FFC, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 1, 0);
        do_req(0, "lh ffff", 0, 0, 2'b01, 32'hFFFF, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 1, 0);
        do_req(0, "sz11 st 4000", 1, 0, 2'b11, 32'h4000, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 0, 1);
        do_req(0, "lw 4000 kept", 0, 0, 2'b10, 32'h4000, 32'h0, 0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
        do_req(0, "sw fffc", 1, 0, 2'b10, 32'hFFFC, 32'hA5A55A5A, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lw fffc", 0, 0, 2'b10, 32'hFFFC, 32'h0, 0, 32'hA5A55A5A, 32'hFFFFFFFF, 0, 0);
        do_req(0, "lw fffe", 0, 0, 2'b10, 32'hFFFE, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 1, 0);

        // Misalign reject on dut_b.
        do_req(1, "b sw 4004", 1, 0, 2'b10, 32'h4004, 32'h01020304, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        do_req(1, "b sw 4008", 1, 0, 2'b10, 32'h4008, 32'h05060708, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        do_req(1, "b sw 4006", 1, 0, 2'b10, 32'h4006, 32'hFFFFFFFF, 0, 32'h0, 32'hFFFFFFFF, 0, 1);
        do_req(1, "b lw 4004", 0, 0, 2'b10, 32'h4004, 32'h0, 0, 32'h01020304, 32'hFFFFFFFF, 0, 0);
        do_req(1, "b lw 4008", 0, 0, 2'b10, 32'h4008, 32'h0, 0, 32'h05060708, 32'hFFFFFFFF, 0, 0);
        do_req(1, "b lh 4007", 0, 0, 2'b01, 32'h4007, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 0, 1);

        // Eight back-to-back aligned loads.
        for (int i = 0; i < 8; i++)
            do_req(0, $sformatf("b2b sw%0d", i), 1, 0, 2'b10, 32'h4010 + 32'(4*i),
                   b2b_val(i), 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        n_rsp = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) begin
                check($sformatf("b2b lw%0d data", n_rsp), bus_a.load_data, b2b_val(n_rsp));
                if (first_k < 0) first_k = k;
                last_k = k;
                n_rsp++;
            end
            if (k < 8) begin
                check($sformatf("b2b ready%0d", k), 32'(bus_a.ready), 32'd1);
                drive(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h4010 + 32'(4*k), 32'h0);
            end else begin
                drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            end
        end
        check("b2b count", 32'(n_rsp), 32'd8);
        check("b2b first", 32'(first_k), 32'd2);
        check("b2b span", 32'(last_k - first_k), 32'd7);

        // Reset while a split store is in SPLIT.
        do_req(0, "sw 4008 old", 1, 0, 2'b10, 32'h4008, 32'h55667788, 0, 32'h0, 32'hFFFFFFFF, 0, 0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h4006, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        check("split ready low", 32'(bus_a.ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst-split ready", 32'(bus_a.ready), 32'd0);
        check("rst-split rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst-split load_data", bus_a.load_data, 32'h0);
        check("rst-split errs", 32'({bus_a.addr_err, bus_a.align_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) n_rsp++;
        end
        check("rst-split no rsp", 32'(n_rsp), 32'd0);
        do_req(0, "lw 4004 beat0", 0, 0, 2'b10, 32'h4004, 32'h0, 0, 32'hF00D0000, 32'hFFFF0000, 0, 0);
        do_req(0, "lw 4008 untouched", 0, 0, 2'b10, 32'h4008, 32'h0, 0, 32'h55667788, 32'hFFFFFFFF, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
